sqrl_uart_frame_ctrl: RTL and testbench



---
 rtl/sqrl_uart_frame_ctrl_if.sv | 33 +++
 rtl/sqrl_uart_frame_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sqrl_uart_frame_ctrl.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrl_uart_frame_ctrl_if.sv
// sqrl_uart_frame_ctrl_if: UART receive byte strobe, payload buffer write
// port and frame valid/ack handshake bundled for the frame controller.
//   master: frame controller side (consumes rx bytes, drives pay_* / frame_*)
//   slave : receiver + consumer side (drives rx bytes and frame_ack)
interface sqrl_uart_frame_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              rx_new_byte;
  logic [7:0]        rx_byte;
  logic              pay_we;
  logic [ADDR_W-1:0] pay_addr;
  logic [7:0]        pay_data;
  logic              frame_valid;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic              frame_ack;
  logic              frame_err;
  logic [1:0]        err_code;

  modport master (
    input  rx_new_byte, rx_byte, frame_ack,
    output pay_we, pay_addr, pay_data,
    output frame_valid, frame_cmd, frame_len,
    output frame_err, err_code
  );

  modport slave (
    output rx_new_byte, rx_byte, frame_ack,
    input  pay_we, pay_addr, pay_data,
    input  frame_valid, frame_cmd, frame_len,
    input  frame_err, err_code
  );
endinterface

// File: rtl/sqrl_uart_frame_ctrl.sv
// sqrl_uart_frame_ctrl: hunts SYNC, parses CMD/LEN/payload/CHK, writes the
// payload buffer, holds good frames until ack, pulses framing errors.
// Ports: clk, reset (sync, active high), bus (sqrl_uart_frame_ctrl_if.master).
// Error codes: 0 overrun, 1 checksum, 2 length, 3 timeout.
// Define SQRL_UART_FRAME_CRC8_EN to use CRC-8 (poly 0x07) instead of XOR.
module sqrl_uart_frame_ctrl #(
  parameter int         comm_clk_frequency = 100000000,
  parameter int         baud_rate          = 115200,
  parameter logic [7:0] SYNC_BYTE          = 8'hA5,
  parameter int         MAX_LEN            = 64,
  parameter int         ADDR_W             = 6,
  parameter int         TIMEOUT_BYTES      = 4
) (
  input logic                   clk,
  input logic                   reset,
  sqrl_uart_frame_ctrl_if.master bus
);
  localparam int TIMEOUT_CYCLES =
    TIMEOUT_BYTES * 10 * (comm_clk_frequency / baud_rate);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [7:0]        acc, acc_n;
  logic [7:0]        idx, idx_n;
  logic [7:0]        cmd_q, cmd_n;
  logic [7:0]        len_q, len_n;
  logic [7:0]        data_q, data_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              we_q, we_n;
  logic              err_q, err_n;
  logic [1:0]        code_q, code_n;
  logic              valid_q;
  logic              hunt_byte;
  logic              active;

  function automatic logic [7:0] fold(
    input logic [7:0] a,
    input logic [7:0] b
  );
`ifdef SQRL_UART_FRAME_CRC8_EN
    logic [7:0] c;
    c = a ^ b;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
`else
    return a ^ b;
`endif
  endfunction

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    acc_n     = acc;
    idx_n     = idx;
    cmd_n     = cmd_q;
    len_n     = len_q;
    we_n      = 1'b0;
    addr_n    = addr_q;
    data_n    = data_q;
    err_n     = 1'b0;
    code_n    = code_q;
    hunt_byte = 1'b0;
    active    = 1'b0;

    unique case (state)
      S_HUNT: hunt_byte = bus.rx_new_byte;
      S_CMD: begin
        active = 1'b1;
        if (bus.rx_new_byte) begin
          cmd_n   = bus.rx_byte;
          acc_n   = fold(acc, bus.rx_byte);
          state_n = S_LEN;
        end
      end
      S_LEN: begin
        active = 1'b1;
        if (bus.rx_new_byte) begin
          if (32'(bus.rx_byte) > MAX_LEN) begin
            err_n   = 1'b1;
            code_n  = 2'd2;
            state_n = S_HUNT;
          end else begin
            len_n   = bus.rx_byte;
            acc_n   = fold(acc, bus.rx_byte);
            idx_n   = '0;
            state_n = (bus.rx_byte == 8'd0) ? S_CHK : S_PAY;
          end
        end
      end
      S_PAY: begin
        active = 1'b1;
        if (bus.rx_new_byte) begin
          we_n   = 1'b1;
          addr_n = idx[ADDR_W-1:0];
          data_n = bus.rx_byte;
          acc_n  = fold(acc, bus.rx_byte);
          idx_n  = idx + 8'd1;
          if (idx + 8'd1 == len_q)
            state_n = S_CHK;
        end
      end
      S_CHK: begin
        active = 1'b1;
        if (bus.rx_new_byte) begin
          if (bus.rx_byte == acc) begin
            state_n = S_HOLD;
          end else begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            state_n = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        // ack releases the frame; a same-cycle byte is a fresh HUNT byte
        if (bus.frame_ack) begin
          state_n   = S_HUNT;
          hunt_byte = bus.rx_new_byte;
        end else if (bus.rx_new_byte) begin
          err_n  = 1'b1;
          code_n = 2'd0;
        end
      end
      default: state_n = S_HUNT;
    endcase

    // a strobe always beats an expiring timer
    if (active && !bus.rx_new_byte) begin
      if (timer == T_LAST) begin
        err_n   = 1'b1;
        code_n  = 2'd3;
        state_n = S_HUNT;
      end else begin
        timer_n = timer + 1'b1;
      end
    end else begin
      timer_n = '0;
    end

    if (state_n == S_HUNT)
      timer_n = '0;

    if (hunt_byte && bus.rx_byte == SYNC_BYTE) begin
      state_n = S_CMD;
      acc_n   = '0;
      timer_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_HUNT;
      timer   <= '0;
      acc     <= '0;
      idx     <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      acc     <= acc_n;
      idx     <= idx_n;
      cmd_q   <= cmd_n;
      len_q   <= len_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      err_q   <= err_n;
      code_q  <= code_n;
      valid_q <= (state_n == S_HOLD);
    end
  end

  assign bus.pay_we      = we_q;
  assign bus.pay_addr    = addr_q;
  assign bus.pay_data    = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_cmd   = cmd_q;
  assign bus.frame_len   = len_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = code_q;
endmodule

// File: tb/tb_sqrl_uart_frame_ctrl.sv
// tb_sqrl_uart_frame_ctrl: random + directed frames checked against a
// queue-based frame model; timeout boundaries checked by cycle counting.
`timescale 1ns/1ps
module tb_sqrl_uart_frame_ctrl;
  localparam int         CLK_HZ   = 1000000;
  localparam int         BAUD     = 100000;
  localparam int         TO_BYTES = 4;
  localparam int         TC       = TO_BYTES * 10 * (CLK_HZ / BAUD);
  localparam int         MAXL     = 64;
  localparam int         AW       = 6;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sqrl_uart_frame_ctrl_if #(.ADDR_W(AW)) bus ();

  sqrl_uart_frame_ctrl #(
    .comm_clk_frequency(CLK_HZ),
    .baud_rate(BAUD),
    .SYNC_BYTE(SYNC),
    .MAX_LEN(MAXL),
    .ADDR_W(AW),
    .TIMEOUT_BYTES(TO_BYTES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // reference model: bytes seen since SYNC, plus the held frame
  bit         m_in;
  bit         m_hold;
  logic [7:0] m_q[$];
  logic [7:0] m_cmd;
  logic [7:0] m_len;
  logic [34:0] obs_v;
  logic [34:0] exp_v;

  function automatic logic [7:0] chk_of(input logic [7:0] q[$]);
    logic [7:0] s;
    s = 8'h00;
`ifdef SQRL_UART_FRAME_CRC8_EN
    // long division of the whole bit stream, MSB first
    foreach (q[i])
      for (int k = 7; k >= 0; k--) begin
        logic fb;
        fb = s[7] ^ q[i][k];
        s  = {s[6:0], 1'b0};
        if (fb) s = s ^ 8'h07;
      end
`else
    foreach (q[i]) s = s ^ q[i];
`endif
    return s;
  endfunction

  function automatic logic [34:0] view();
    return {bus.pay_we,
            bus.pay_we ? bus.pay_addr : AW'(0),
            bus.pay_we ? bus.pay_data : 8'h00,
            bus.frame_err,
            bus.frame_err ? bus.err_code : 2'd0,
            bus.frame_valid,
            bus.frame_valid ? bus.frame_cmd : 8'h00,
            bus.frame_valid ? bus.frame_len : 8'h00};
  endfunction

  function automatic logic [34:0] raw();
    return {bus.pay_we, bus.pay_addr, bus.pay_data,
            bus.frame_err, bus.err_code, bus.frame_valid,
            bus.frame_cmd, bus.frame_len};
  endfunction

  function automatic logic [34:0] hold_exp();
    return {1'b0, AW'(0), 8'h00, 1'b0, 2'd0, m_hold,
            m_hold ? m_cmd : 8'h00, m_hold ? m_len : 8'h00};
  endfunction

  task automatic model_reset();
    m_in = 1'b0;
    m_hold = 1'b0;
    m_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ack);
    logic          we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          err;
    logic [1:0]    c;
    int            n;
    we = 1'b0; a = '0; d = 8'h00; err = 1'b0; c = 2'd0;
    if (m_hold && !ack) begin
      err = 1'b1;
      c = 2'd0;
    end else begin
      m_hold = 1'b0;
      if (!m_in) begin
        if (b == SYNC) begin
          m_in = 1'b1;
          m_q.delete();
        end
      end else begin
        n = m_q.size();
        if (n == 1 && int'(b) > MAXL) begin
          err = 1'b1; c = 2'd2; m_in = 1'b0;
        end else if (n >= 2 && n == 2 + int'(m_q[1])) begin
          if (b == chk_of(m_q)) begin
            m_hold = 1'b1; m_cmd = m_q[0]; m_len = m_q[1];
          end else begin
            err = 1'b1; c = 2'd1;
          end
          m_in = 1'b0;
        end else begin
          if (n >= 2) begin
            we = 1'b1; a = AW'(n - 2); d = b;
          end
          m_q.push_back(b);
        end
      end
    end
    exp_v = {we, a, d, err, c, m_hold,
             m_hold ? m_cmd : 8'h00, m_hold ? m_len : 8'h00};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_new_byte = 1'b0;
    bus.rx_byte = 8'h00;
    bus.frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_byte(input logic [7:0] b, input bit ack);
    bus.rx_new_byte = 1'b1;
    bus.rx_byte = b;
    bus.frame_ack = ack;
    @(negedge clk);
    bus.rx_new_byte = 1'b0;
    bus.frame_ack = 1'b0;
    obs_v = view();
    model_byte(b, ack);
  endtask

  task automatic run_ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    obs_v = view();
    m_hold = 1'b0;
    exp_v = hold_exp();
  endtask

  task automatic idle(input int k, output int bad);
    bad = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (bus.frame_err || bus.pay_we) bad++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (raw() !== 35'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 0", raw());
    end
  endtask

  task automatic test_good_frame();
    logic [7:0]  fr[6] = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h11};
    logic [14:0] w[2];
    do_reset();
    foreach (fr[i]) begin
      run_byte(fr[i], 1'b0);
      if (i >= 3 && i <= 4)
        w[i-3] = {bus.pay_we, bus.pay_addr, bus.pay_data};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL good byte %0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (w[0] !== {1'b1, 6'd0, 8'h01} || w[1] !== {1'b1, 6'd1, 8'h02}) begin
      errors++;
      $display("FAIL good pay writes: got %h %h want 4001 4102", w[0], w[1]);
    end
    checks++;
    if ({bus.frame_valid, bus.frame_cmd, bus.frame_len} !== {1'b1, 8'h10, 8'h02}) begin
      errors++;
      $display("FAIL good held: got %b %h %h want 1 10 02",
               bus.frame_valid, bus.frame_cmd, bus.frame_len);
    end
    run_ack();
    checks++;
    if (bus.frame_valid !== 1'b0 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL good ack: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_zero_len_noise();
    logic [7:0] fr[6] = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h20};
    int nerr;
    int nwe;
    do_reset();
    nerr = 0;
    nwe = 0;
    foreach (fr[i]) begin
      run_byte(fr[i], 1'b0);
      if (bus.frame_err) nerr++;
      if (bus.pay_we) nwe++;
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL zlen byte %0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (nerr !== 0 || nwe !== 0 || bus.frame_valid !== 1'b1 ||
        bus.frame_len !== 8'h00) begin
      errors++;
      $display("FAIL zlen summary: err %0d we %0d valid %b len %h want 0 0 1 00",
               nerr, nwe, bus.frame_valid, bus.frame_len);
    end
    run_ack();
  endtask

  task automatic test_bad_checksum();
    logic [7:0] fr[10] = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h12,
                           8'hA5, 8'h30, 8'h00, 8'h30};
    do_reset();
    foreach (fr[i]) begin
      run_byte(fr[i], 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL badchk byte %0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 5) begin
        checks++;
        if ({bus.frame_err, bus.err_code, bus.frame_valid} !== {1'b1, 2'd1, 1'b0}) begin
          errors++;
          $display("FAIL badchk err: got %b %0d %b want 1 1 0",
                   bus.frame_err, bus.err_code, bus.frame_valid);
        end
      end
    end
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h30) begin
      errors++;
      $display("FAIL badchk recover: got %b %h want 1 30",
               bus.frame_valid, bus.frame_cmd);
    end
    run_ack();
  endtask

  task automatic test_length();
    logic [7:0] body[$];
    do_reset();
    run_byte(SYNC, 1'b0);
    run_byte(8'h10, 1'b0);
    run_byte(8'h41, 1'b0);
    checks++;
    if ({bus.frame_err, bus.err_code} !== {1'b1, 2'd2} || obs_v !== exp_v) begin
      errors++;
      $display("FAIL len 0x41: got %b %0d want 1 2", bus.frame_err, bus.err_code);
    end
    // largest legal length fills every buffer address
    body = '{8'h10, 8'h40};
    run_byte(SYNC, 1'b0);
    run_byte(8'h10, 1'b0);
    run_byte(8'h40, 1'b0);
    for (int i = 0; i < MAXL; i++) begin
      body.push_back(8'($urandom));
      run_byte(body[$], 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL len64 pay %0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    run_byte(chk_of(body), 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_len !== 8'h40 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL len64 held: got %b %h want 1 40", bus.frame_valid, bus.frame_len);
    end
    run_ack();
  endtask

  task automatic test_timeout();
    int         first;
    int         bad;
    logic [1:0] code;
    logic [7:0] body[$];
    do_reset();
    run_byte(SYNC, 1'b0);
    run_byte(8'h10, 1'b0);
    first = -1;
    code = 2'd0;
    for (int i = 1; i <= TC + 3; i++) begin
      @(negedge clk);
      if (bus.frame_err && first < 0) begin
        first = i;
        code = bus.err_code;
      end
    end
    m_in = 1'b0;
    checks++;
    if (first !== TC || code !== 2'd3) begin
      errors++;
      $display("FAIL timeout: at cycle %0d code %0d want %0d 3", first, code, TC);
    end
    // strobes landing TC-1 and TC cycles after the previous one
    body = '{8'h10, 8'h01, 8'h7E};
    run_byte(SYNC, 1'b0);
    run_byte(body[0], 1'b0);
    idle(TC - 2, bad);
    run_byte(body[1], 1'b0);
    checks++;
    if (bad !== 0 || obs_v !== exp_v || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL strobe at TC-1: bad %0d got %h want %h", bad, obs_v, exp_v);
    end
    idle(TC - 1, bad);
    run_byte(body[2], 1'b0);
    checks++;
    if (bad !== 0 || obs_v !== exp_v || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL strobe at TC: bad %0d got %h want %h", bad, obs_v, exp_v);
    end
    run_byte(chk_of(body), 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL timeout-survivor: got %h want %h", obs_v, exp_v);
    end
    idle(TC + 5, bad);
    checks++;
    if (bad !== 0 || bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold no-timer: bad %0d valid %b want 0 1", bad, bus.frame_valid);
    end
    run_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] fr[4] = '{8'hA5, 8'h20, 8'h00, 8'h20};
    logic [7:0] nx[3] = '{8'h30, 8'h00, 8'h30};
    do_reset();
    foreach (fr[i]) run_byte(fr[i], 1'b0);
    run_byte(8'h55, 1'b0);
    checks++;
    if ({bus.frame_err, bus.err_code, bus.frame_valid} !== {1'b1, 2'd0, 1'b1} ||
        obs_v !== exp_v) begin
      errors++;
      $display("FAIL overrun: got %h want %h", obs_v, exp_v);
    end
    run_byte(SYNC, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b0 || bus.frame_valid !== 1'b0 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL ack+sync: got %h want %h", obs_v, exp_v);
    end
    foreach (nx[i]) begin
      run_byte(nx[i], 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL after ack+sync %0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h30) begin
      errors++;
      $display("FAIL ack+sync frame: got %b %h want 1 30",
               bus.frame_valid, bus.frame_cmd);
    end
    run_ack();
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr[5] = '{8'hA5, 8'h10, 8'h04, 8'h01, 8'h02};
    logic [7:0] nx[4] = '{8'hA5, 8'h30, 8'h00, 8'h30};
    foreach (fr[i]) run_byte(fr[i], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (raw() !== 35'd0) begin
      errors++;
      $display("FAIL reset mid-pay: got %h want 0", raw());
    end
    reset = 1'b0;
    model_reset();
    foreach (nx[i]) run_byte(nx[i], 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b1 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL after reset: got %h want %h", obs_v, exp_v);
    end
    run_ack();
  endtask

  task automatic test_random_frames();
    logic [7:0] fq[$];
    logic [7:0] body[$];
    logic [7:0] b;
    int         len;
    int         bad;
    bit         ack_next;
    do_reset();
    ack_next = 1'b0;
    for (int f = 0; f < 30; f++) begin
      fq.delete();
      body.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        fq.push_back(b);
      end
      fq.push_back(SYNC);
      body.push_back(8'($urandom));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXL + 1, 255)
                                        : $urandom_range(0, 9);
      body.push_back(8'(len));
      if (len <= MAXL)
        for (int i = 0; i < len; i++) body.push_back(8'($urandom));
      foreach (body[i]) fq.push_back(body[i]);
      if (len <= MAXL) begin
        b = chk_of(body);
        if ($urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
        fq.push_back(b);
      end
      foreach (fq[i]) begin
        run_byte(fq[i], (i == 0) ? ack_next : 1'b0);
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL rand f%0d b%0d: got %h want %h", f, i, obs_v, exp_v);
        end
        idle($urandom_range(0, 2), bad);
        checks++;
        if (bad !== 0) begin
          errors++;
          $display("FAIL rand idle f%0d: got %0d stray pulses want 0", f, bad);
        end
      end
      ack_next = 1'b0;
      if (m_hold) begin
        if ($urandom_range(0, 1) == 1) begin
          ack_next = 1'b1;
        end else begin
          run_ack();
          checks++;
          if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL rand ack f%0d: got %h want %h", f, obs_v, exp_v);
          end
        end
      end
    end
    if (m_hold) run_ack();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_zero_len_noise();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
